// File: rtl/bias_activation_if.sv
// rtl/bias_activation_if.sv - bundled control, source/bias read and destination write signals
// The slave modport is the bias_activation block; the master is its environment.
interface bias_activation_if #(
  parameter int LEN_BITS = 4
);
  logic                start;
  logic [1:0]          act_mode;
  logic [15:0]         src_data;
  logic [LEN_BITS-1:0] src_sel;
  logic [15:0]         bias_data;
  logic [LEN_BITS-1:0] bias_sel;
  logic                dst_we;
  logic [LEN_BITS-1:0] dst_sel;
  logic [15:0]         dst_data;
  logic                ready;
  logic                done;

  modport slave (
    input  start, act_mode, src_data, bias_data,
    output src_sel, bias_sel, dst_we, dst_sel, dst_data, ready, done
  );

  modport master (
    output start, act_mode, src_data, bias_data,
    input  src_sel, bias_sel, dst_we, dst_sel, dst_data, ready, done
  );
endinterface

// File: rtl/bias_activation.sv
// rtl/bias_activation.sv - two-stage bias-add + saturate + activation over a 2**LEN_BITS vector
// Stage 1 registers sat16(src+bias); stage 2 registers the activated value and the write strobe.
module bias_activation #(
  parameter int LEN_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  bias_activation_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [LEN_BITS-1:0] LAST = '1;

  state_t              state_q, state_d;
  logic [LEN_BITS-1:0] idx_q, idx_d;
  logic [1:0]          mode_q, mode_d;
  logic                s1_v_q, s1_v_d;
  logic [LEN_BITS-1:0] s1_idx_q, s1_idx_d;
  logic signed [15:0]  s1_sum_q, s1_sum_d;
  logic                dst_we_q, dst_we_d;
  logic [LEN_BITS-1:0] dst_sel_q, dst_sel_d;
  logic [15:0]         dst_data_q, dst_data_d;
  logic                done_q, done_d;
  logic signed [16:0]  sum17;

  function automatic logic signed [15:0] act_f(input logic [1:0] m, input logic signed [15:0] x);
    logic signed [15:0] h;
    // x >>> 2 spans [-8192, 8191], so the +128 offset cannot overflow 16 bits.
    h = (x >>> 2) + 16'sd128;
    case (m)
      2'd0:    act_f = x;
      2'd1:    act_f = (x > 16'sd0) ? x : 16'sd0;
      2'd2:    act_f = (x > 16'sd256) ? 16'sd256 : ((x < -16'sd256) ? -16'sd256 : x);
      default: act_f = (h < 16'sd0) ? 16'sd0 : ((h > 16'sd256) ? 16'sd256 : h);
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    sum17      = $signed({bus.src_data[15], bus.src_data}) + $signed({bus.bias_data[15], bus.bias_data});
    s1_v_d     = (state_q == RUN);
    s1_idx_d   = idx_q;
    if (sum17 > 17'sd32767)       s1_sum_d = 16'sh7FFF;
    else if (sum17 < -17'sd32768) s1_sum_d = 16'sh8000;
    else                          s1_sum_d = sum17[15:0];
    dst_we_d   = s1_v_q;
    dst_sel_d  = s1_v_q ? s1_idx_q : dst_sel_q;
    dst_data_d = s1_v_q ? act_f(mode_q, s1_sum_q) : dst_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          mode_d  = bus.act_mode;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (idx_q == LAST) begin
          state_d = FLUSH;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FLUSH: begin
        // Final element is being written now and nothing is left behind it.
        if (dst_we_q && !s1_v_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mode_q     <= 2'd0;
      s1_v_q     <= 1'b0;
      s1_idx_q   <= '0;
      s1_sum_q   <= 16'sd0;
      dst_we_q   <= 1'b0;
      dst_sel_q  <= '0;
      dst_data_q <= 16'h0000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      s1_v_q     <= s1_v_d;
      s1_idx_q   <= s1_idx_d;
      s1_sum_q   <= s1_sum_d;
      dst_we_q   <= dst_we_d;
      dst_sel_q  <= dst_sel_d;
      dst_data_q <= dst_data_d;
      done_q     <= done_d;
    end
  end

  assign bus.src_sel  = idx_q;
  assign bus.bias_sel = idx_q;
  assign bus.dst_we   = dst_we_q;
  assign bus.dst_sel  = dst_sel_q;
  assign bus.dst_data = dst_data_q;
  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
endmodule

// File: doc/bias_activation.md
BIAS_ACTIVATION -- requirements
Module: bias_activation

Interface
REQ-001 Parameter: LEN_BITS, default 4, vector index width; the block processes 2**LEN_BITS elements per run.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  begin a run; sampled only in IDLE.
REQ-005 act_mode  input  2  activation select: 0 identity, 1 ReLU, 2 hard-tanh, 3 hard-sigmoid.
REQ-006 src_data  input  16  signed Q8.8 matmul accumulator element, combinational read of src_sel.
REQ-007 src_sel  output  LEN_BITS  accumulator element index.
REQ-008 bias_data  input  16  signed Q8.8 bias element, combinational read of bias_sel.
REQ-009 bias_sel  output  LEN_BITS  bias element index; always equals src_sel.
REQ-010 dst_we  output  1  write strobe to the destination vector.
REQ-011 dst_sel  output  LEN_BITS  destination index.
REQ-012 dst_data  output  16  signed Q8.8 activated result.
REQ-013 ready  output  1  high only in IDLE.
REQ-014 done  output  1  one-cycle pulse at run completion.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FLUSH.
REQ-016 IDLE with start=1 SHALL go to RUN, latch act_mode, and set the issue index to 0.
REQ-017 In RUN the block SHALL issue one index per cycle on src_sel/bias_sel, 0 to 2**LEN_BITS-1, then go to FLUSH after the last index.
REQ-018 Stage 1 SHALL register sum = sat16(src_data + bias_data), computed at 17 bits, together with the index and a valid bit.
REQ-019 sat16 SHALL clamp to [-32768, 32767].
REQ-020 Stage 2 SHALL register dst_data = act(sum), with dst_sel = index and dst_we = stage-1 valid.
REQ-021 Latency SHALL be 2 cycles from index issue to the dst_we cycle; throughput is one element per cycle.
REQ-022 Identity: act(x) = x.
REQ-023 ReLU: act(x) = x if x > 0, else 0.
REQ-024 Hard-tanh: act(x) = clamp(x, -256, 256).
REQ-025 Hard-sigmoid: act(x) = clamp((x >>> 2) + 128, 0, 256), with an arithmetic shift and no overflow at the extremes.
REQ-026 The activation SHALL use the act_mode latched at start; changes to act_mode mid-run SHALL have no effect.
REQ-027 FLUSH SHALL last until the pipeline drains.
REQ-028 done SHALL pulse in the cycle after the final dst_we; the FSM SHALL return to IDLE in that same cycle.
REQ-029 ready SHALL be 0 from the cycle after start is accepted until done.
REQ-030 start outside IDLE SHALL be ignored; it is not queued.
REQ-031 start held high in IDLE on the done/return cycle SHALL launch a new run on the next edge.
REQ-032 dst_we SHALL be asserted exactly 2**LEN_BITS times per run, for indices 0..2**LEN_BITS-1 in ascending order, with no gaps.
REQ-033 In IDLE, src_sel/bias_sel SHALL hold 0; dst_we SHALL be 0; dst_data and dst_sel SHALL hold their last values.
REQ-034 An index wrap past 2**LEN_BITS-1 SHALL never occur within a run.

Reset
REQ-035 rst=1 SHALL asynchronously force:
- state to IDLE;
- src_sel, bias_sel, dst_sel and dst_data to 0;
- dst_we, done and both valid bits to 0;
- ready to 1.
REQ-036 rst asserted mid-run SHALL abort the run: no further dst_we and no done; the destination contents written so far are undefined to the consumer.
REQ-037 After rst deasserts, the block SHALL accept start on the first clock edge.

Verification
REQ-038 Reset then idle: rst pulse, start=0 for 10 cycles -> ready=1, dst_we=0, done=0 throughout.
REQ-039 Identity, LEN_BITS=4, src[i]=i*256, bias[i]=-128 -> 16 writes on consecutive cycles, with:
- dst[i]=i*256-128;
- first dst_we 2 cycles after the first RUN cycle;
- done one cycle after dst[15].
REQ-040 Saturation, identity: src=0x7F00, bias=0x0200 -> dst=0x7FFF; src=0x8100, bias=0xFE00 -> dst=0x8000.
REQ-041 Activations, src+bias values {-512, -64, 0, 64, 512}:
- ReLU -> {0, 0, 0, 64, 512};
- hard-tanh -> {-256, -64, 0, 64, 256};
- hard-sigmoid -> {0, 112, 128, 144, 256}.
REQ-042 Start while busy and act_mode change mid-run: 2nd start pulse at element 5, act_mode flipped 1->2 -> exactly 16 writes, all with ReLU, one done, no second run.
REQ-043 Reset mid-run: rst asserted at element 7 -> dst_we=0 immediately, no done, ready=1; a subsequent start runs a full, correct 16-element pass.
